// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multiport register file
package regfile_pkg;

    // Register that is hard-wired to zero: never written, never busy.
    localparam int ZERO_REG = 0;

    // Write port that wins when both ports target the same register.
    localparam logic WR_WIN_PORT = 1'b1;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with write bypass and busy flag
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]             ra,
    input  logic [DEPTH-1:0][N-1:0]   regs,
    input  logic [DEPTH-1:0]          busy,
    input  logic                      hi_v,
    input  logic [AW-1:0]             hi_a,
    input  logic [N-1:0]              hi_d,
    input  logic                      lo_v,
    input  logic [AW-1:0]             lo_a,
    input  logic [N-1:0]              lo_d,
    output logic [N-1:0]              rd,
    output logic                      rb
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic ra_ok;
    logic hit_hi;
    logic hit_lo;

    assign ra_ok  = (ra != AW'(ZERO_REG)) && ({1'b0, ra} < DEPTH_L);
    assign hit_hi = ra_ok && hi_v && (hi_a == ra);
    assign hit_lo = ra_ok && lo_v && (lo_a == ra);

    // Select bypassed write data (winning port first), else stored value; zero/out-of-range read 0.
    always_comb begin
        rd = '0;
        rb = 1'b0;
        if (ra_ok) begin
            if (hit_hi) begin
                rd = hi_d;
            end else if (hit_lo) begin
                rd = lo_d;
            end else begin
                rd = regs[ra];
            end
            rb = busy[ra] && !(hit_hi || hit_lo);
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - 2-read/2-write register file with reservation scoreboard
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            ra0,
    input  logic [AW-1:0]            ra1,
    output logic [N-1:0]             rd0,
    output logic [N-1:0]             rd1,
    output logic                     rb0,
    output logic                     rb1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [AW-1:0]            wa0,
    input  logic [AW-1:0]            wa1,
    input  logic [N-1:0]             wd0,
    input  logic [N-1:0]             wd1,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [cnt_w(DEPTH)-1:0]  busy_cnt
);

    localparam int          CW      = cnt_w(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0][N-1:0] regs;
    logic [DEPTH-1:0]        busy;

    logic          wv0, wv1, rv;
    logic          hi_v, lo_v;
    logic [AW-1:0] hi_a, lo_a;
    logic [N-1:0]  hi_d, lo_d;
    logic          set_new, clr_hi, clr_lo;
    logic [CW-1:0] cnt_next;

    // Nonzero and below DEPTH; anything else is ignored for write/reserve.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(ZERO_REG)) && ({1'b0, a} < DEPTH_L);
    endfunction

    // Requests seen during reset are discarded, including their bypass.
    assign wv0 = !rst && we0 && addr_ok(wa0);
    assign wv1 = !rst && we1 && addr_ok(wa1);
    assign rv  = !rst && rsv_en && addr_ok(rsv_addr);

    // Order the write ports by priority: "hi" is applied last and wins conflicts.
    assign hi_v = WR_WIN_PORT ? wv1 : wv0;
    assign hi_a = WR_WIN_PORT ? wa1 : wa0;
    assign hi_d = WR_WIN_PORT ? wd1 : wd0;
    assign lo_v = WR_WIN_PORT ? wv0 : wv1;
    assign lo_a = WR_WIN_PORT ? wa0 : wa1;
    assign lo_d = WR_WIN_PORT ? wd0 : wd1;

    // Register storage; the winning port's assignment comes last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            if (lo_v) regs[lo_a] <= lo_d;
            if (hi_v) regs[hi_a] <= hi_d;
        end
    end

    // Scoreboard bits: writes clear, a same-cycle reserve overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (lo_v) busy[lo_a] <= 1'b0;
            if (hi_v) busy[hi_a] <= 1'b0;
            if (rv)   busy[rsv_addr] <= 1'b1;
        end
    end

    // Count only real bit transitions so busy_cnt tracks the popcount of busy.
    always_comb begin
        set_new  = rv && !busy[rsv_addr];
        clr_hi   = hi_v && busy[hi_a] && !(rv && (rsv_addr == hi_a));
        clr_lo   = lo_v && busy[lo_a] && !(rv && (rsv_addr == lo_a))
                   && !(hi_v && (hi_a == lo_a));
        cnt_next = busy_cnt + CW'(set_new) - CW'(clr_hi) - CW'(clr_lo);
    end

    // Registered busy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= cnt_next;
        end
    end

    rf_read_port #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_rp0 (
        .ra   (ra0),
        .regs (regs),
        .busy (busy),
        .hi_v (hi_v),
        .hi_a (hi_a),
        .hi_d (hi_d),
        .lo_v (lo_v),
        .lo_a (lo_a),
        .lo_d (lo_d),
        .rd   (rd0),
        .rb   (rb0)
    );

    rf_read_port #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_rp1 (
        .ra   (ra1),
        .regs (regs),
        .busy (busy),
        .hi_v (hi_v),
        .hi_a (hi_a),
        .hi_d (hi_d),
        .lo_v (lo_v),
        .lo_a (lo_a),
        .lo_d (lo_d),
        .rd   (rd1),
        .rb   (rb1)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed self-checking bench for multiport_regfile
module tb_multiport_regfile;

    localparam int N     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra0 = '0, ra1 = '0;
    logic [N-1:0]  rd0, rd1;
    logic          rb0, rb1;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] wa0 = '0, wa1 = '0;
    logic [N-1:0]  wd0 = '0, wd1 = '0;
    logic          rsv_en = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    logic [CW-1:0] busy_cnt;

    int compared   = 0;
    int mismatched = 0;

    multiport_regfile #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ra0      (ra0),
        .ra1      (ra1),
        .rd0      (rd0),
        .rd1      (rd1),
        .rb0      (rb0),
        .rb1      (rb1),
        .we0      (we0),
        .we1      (we1),
        .wa0      (wa0),
        .wa1      (wa1),
        .wd0      (wd0),
        .wd1      (wd1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();

        // reset state
        ra0 = 5'd0; ra1 = 5'd31; #1;
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_rb0", rb0, 0);
        chk("rst_rb1", rb1, 0);
        chk("rst_cnt", busy_cnt, 0);

        // bypass then stored value
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra0 = 5; #1;
        chk("byp_rd0", rd0, 32'hDEADBEEF);
        tick(); idle(); #1;
        chk("stored_rd0", rd0, 32'hDEADBEEF);

        // same-address double write: port 1 wins
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22; ra0 = 7; #1;
        chk("dual_byp", rd0, 32'h22);
        tick(); idle(); ra1 = 7; #1;
        chk("dual_stored", rd1, 32'h22);

        // register 0 ignores writes and reserves
        we1 = 1; wa1 = 0; wd1 = 32'hFFFF; ra0 = 0; #1;
        chk("r0_byp", rd0, 0);
        tick(); idle(); #1;
        chk("r0_stored", rd0, 0);
        rsv_en = 1; rsv_addr = 0;
        tick(); idle(); #1;
        chk("r0_rsv_cnt", busy_cnt, 0);

        // reserve 3 then 4
        rsv_en = 1; rsv_addr = 3;
        tick(); rsv_addr = 4;
        tick(); idle(); ra0 = 3; ra1 = 4; #1;
        chk("rsv_cnt2", busy_cnt, 2);
        chk("rsv_rb0", rb0, 1);
        chk("rsv_rb1", rb1, 1);

        // write+reserve same reg: reserve wins; rb masked during the write
        we0 = 1; wa0 = 3; wd0 = 32'h33; rsv_en = 1; rsv_addr = 3; #1;
        chk("wr_rsv_rb0", rb0, 0);
        tick(); idle(); #1;
        chk("wr_rsv_cnt", busy_cnt, 2);
        chk("wr_rsv_rb0b", rb0, 1);
        chk("wr_rsv_rd0", rd0, 32'h33);

        // reserve already-busy register
        rsv_en = 1; rsv_addr = 4;
        tick(); idle(); #1;
        chk("rersv_cnt", busy_cnt, 2);

        // release 3 and 4 together
        we0 = 1; wa0 = 3; wd0 = 32'h300; we1 = 1; wa1 = 4; wd1 = 32'h400;
        tick(); idle(); #1;
        chk("rel_cnt", busy_cnt, 0);
        chk("rel_rb0", rb0, 0);
        chk("rel_rb1", rb1, 0);
        chk("rel_rd0", rd0, 32'h300);
        chk("rel_rd1", rd1, 32'h400);

        // write to non-busy reg alongside a reserve of another
        we0 = 1; wa0 = 9; wd0 = 32'h9; rsv_en = 1; rsv_addr = 10;
        tick(); idle(); #1;
        chk("nb_cnt", busy_cnt, 1);
        // clear 10 while reserving 11
        we0 = 1; wa0 = 10; rsv_en = 1; rsv_addr = 11;
        tick(); idle(); ra0 = 11; ra1 = 10; #1;
        chk("swap_cnt", busy_cnt, 1);
        chk("swap_rb0", rb0, 1);
        chk("swap_rb1", rb1, 0);
        // both ports clear the same busy register: single decrement
        rsv_en = 1; rsv_addr = 12;
        tick(); idle(); #1;
        chk("r12_cnt", busy_cnt, 2);
        we0 = 1; we1 = 1; wa0 = 12; wa1 = 12;
        tick(); idle(); #1;
        chk("dual_clr_cnt", busy_cnt, 1);
        rsv_en = 1; rsv_addr = 13;
        tick(); idle(); ra0 = 5; ra1 = 13; #1;
        chk("pre_rst_cnt", busy_cnt, 2);
        chk("pre_rst_rb1", rb1, 1);
        chk("pre_rst_rd0", rd0, 32'hDEADBEEF);

        // asynchronous reset between edges
        rst = 1; #1;
        chk("arst_cnt", busy_cnt, 0);
        chk("arst_rb1", rb1, 0);
        chk("arst_rd0", rd0, 0);

        // requests during reset are discarded
        we0 = 1; wa0 = 6; wd0 = 32'h66; rsv_en = 1; rsv_addr = 6;
        tick(); idle(); rst = 0; ra0 = 6; #1;
        chk("rstwr_rd0", rd0, 0);
        chk("rstwr_cnt", busy_cnt, 0);

        // bypass in the first cycle after reset
        we1 = 1; wa1 = 6; wd1 = 32'h77; #1;
        chk("post_rst_byp", rd0, 32'h77);
        tick(); idle(); #1;
        chk("post_rst_rd0", rd0, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers, range 2..64, need not be a power of two.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), register address width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports ra0, ra1  input  AW  read addresses, ports A and B.
REQ-007 SHALL have ports rd0, rd1  output  N  read data, ports A and B.
REQ-008 SHALL have ports rb0, rb1  output  1  read-register-busy flags, ports A and B.
REQ-009 SHALL have ports we0, we1  input  1  write enables, write ports 0 and 1.
REQ-010 SHALL have ports wa0, wa1  input  AW  write addresses.
REQ-011 SHALL have ports wd0, wd1  input  N  write data.
REQ-012 SHALL have port rsv_en  input  1  reserve request; marks a destination register pending.
REQ-013 SHALL have port rsv_addr  input  AW  register to reserve.
REQ-014 SHALL have port busy_cnt  output  $clog2(DEPTH+1)  number of registers currently pending.

Function
REQ-015 Reads SHALL be combinational with zero-cycle latency.
REQ-016 Register 0 SHALL always read 0, SHALL never be written and SHALL never be busy.
REQ-017 Any address >= DEPTH SHALL read 0, SHALL be ignored on write and SHALL be ignored on reserve.
REQ-018 Writes SHALL commit at the rising clk edge: regs[wa] <= wd when we is high and wa is in the range 1..DEPTH-1.
REQ-019 When both ports write the same address in one cycle, port 1 SHALL win.
REQ-020 Bypass: when a valid write to ra is enabled in the current cycle, rd SHALL equal that write's data, with port 1 taking precedence over port 0; otherwise rd SHALL equal regs[ra].
REQ-021 Scoreboard: a valid rsv_en SHALL set busy[rsv_addr] at the clock edge.
REQ-022 Any valid write SHALL clear busy[wa] at the clock edge.
REQ-023 When a reserve and a write target the same register in the same cycle, the reserve SHALL win and the register SHALL stay busy.
REQ-024 A reserve of a register that is already busy SHALL leave it busy and SHALL NOT change busy_cnt.
REQ-025 rb SHALL equal busy[ra] AND NOT (a valid write to ra in the current cycle).
REQ-026 busy_cnt SHALL be a registered count: +1 per register newly set, -1 per register newly cleared, net change in {-2..+1} per cycle.
REQ-027 busy_cnt SHALL always equal the population count of busy[] and SHALL never wrap.
REQ-028 A write to a non-busy register SHALL be legal and SHALL leave busy_cnt unchanged.

Reset
REQ-029 Asserting rst SHALL immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-030 Writes or reserves presented while rst is high SHALL be discarded.
REQ-031 Reset asserted mid-sequence SHALL drop all pending reservations.
REQ-032 After reset, rd0 and rd1 SHALL read 0, except where bypass applies in the first cycle after rst deasserts.

Structure
REQ-033 Shared package regfile_pkg SHALL hold: the busy-count width function, the zero-register index constant, and the write-port priority constant.
REQ-034 One sub-module, rf_read_port, SHALL be instantiated twice; it contains the address-range check, the bypass mux and the rb logic.
REQ-035 Storage, write logic and scoreboard SHALL remain in multiport_regfile.

Verification
REQ-036 Reset, then ra0=0 and ra1=31, no writes -> rd0=0, rd1=0, rb0=rb1=0, busy_cnt=0.
REQ-037 we0=1, wa0=5, wd0=0xDEADBEEF and ra0=5 in the same cycle -> rd0=0xDEADBEEF that cycle (bypass); next cycle with we0=0 -> rd0 still 0xDEADBEEF.
REQ-038 we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> regs[7]=0x22; same-cycle read of 7 -> 0x22.
REQ-039 we1=1, wa1=0, wd1=0xFFFF -> rd of reg 0 stays 0; rsv_en=1 with rsv_addr=0 -> busy_cnt stays 0.
REQ-040 Reserve 3, then 4 -> busy_cnt=2, rb for 3 =1.
REQ-041 Follow REQ-040 with: write 3 and reserve 3 in the same cycle -> reg 3 stays busy, busy_cnt=2; then write 3 and write 4 -> busy_cnt=0.
REQ-042 rst pulse between clock edges with busy_cnt=2 -> busy_cnt=0 and all rb=0 immediately.
